pueo_beam_trig_out: RTL and testbench
=====================================

PUEO_BEAM_TRIG_OUT -- requirements
Module: pueo_beam_trig_out

Interface
REQ-001 Parameter NUM_BEAMS, default 2, number of beam trigger inputs (matches the dummy beam set).
REQ-002 Parameter HOLDOFF, default 4, number of cycles after an accepted event during which new events are ignored; legal range 1..255.
REQ-003 Parameter FIFO_DEPTH, default 4, number of event entries buffered; power of two, minimum 2.
REQ-004 aclk  in  1  single clock for all logic.
REQ-005 aresetn  in  1  reset; asynchronous assertion, active-low.
REQ-006 trig_i  in  NUM_BEAMS  per-beam threshold-crossing flags from the beamformer, one bit per beam, sampled every cycle.
REQ-007 mask_i  in  NUM_BEAMS  beam mask value; 1 = beam disabled.
REQ-008 mask_we_i  in  1  loads mask_i into the internal mask register.
REQ-009 m_tdata  out  16+NUM_BEAMS  event word: [NUM_BEAMS-1:0] = masked beam bits, [NUM_BEAMS+15:NUM_BEAMS] = timestamp.
REQ-010 m_tvalid  out  1  event word available.
REQ-011 m_tready  in  1  consumer accepts the word when m_tvalid and m_tready are both high.
REQ-012 overflow_o  out  8  saturating count of events dropped because the FIFO was full.

Function
REQ-013 The block SHALL keep a free-running 16-bit timestamp counter that increments every cycle and wraps from 0xFFFF to 0x0000.
REQ-014 The effective beam bits for a cycle SHALL be trig_i AND NOT mask, using the mask register value held at the start of that cycle.
REQ-015 Asserting mask_we_i in cycle N SHALL update the mask register so that the new mask applies to trig_i from cycle N+1.
REQ-016 The event FSM SHALL have exactly two states: IDLE and HOLD.
REQ-017 In IDLE, a cycle with nonzero effective beam bits SHALL be an event: the FSM captures {timestamp of that cycle, effective bits}, moves to HOLD, and loads the holdoff counter with HOLDOFF-1.
REQ-018 In HOLD, the counter SHALL decrement each cycle and the FSM SHALL return to IDLE in the cycle after the counter reads 0; trig_i SHALL be ignored throughout HOLD.
REQ-019 The FSM SHALL enter HOLD on an event whether or not the event is stored in the FIFO.
REQ-020 A captured event SHALL be pushed into the FIFO one cycle after the trig_i cycle. With the FIFO empty, m_tvalid SHALL assert two cycles after that trig_i cycle.
REQ-021 The FIFO SHALL be first-word fall-through: m_tdata is valid whenever m_tvalid is high, and it SHALL hold steady until accepted.
REQ-022 A push while the FIFO is full SHALL be accepted only if a pop happens in the same cycle. Otherwise the event is dropped and overflow_o increments.
REQ-023 overflow_o SHALL saturate at 255 and SHALL NOT wrap.
REQ-024 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the occupancy unchanged and SHALL keep the order of entries.
REQ-025 m_tvalid SHALL NOT depend combinationally on m_tready.

Reset
REQ-026 While aresetn is low, the following SHALL hold: m_tvalid = 0, m_tdata = 0, overflow_o = 0, FIFO empty, FSM = IDLE, holdoff counter = 0, timestamp = 0, mask register = all zeros (all beams enabled).
REQ-027 Reset asserted mid-operation SHALL discard all queued events and any event captured but not yet pushed.
REQ-028 The first event SHALL be detectable on the first rising edge of aclk after aresetn deasserts.

Verification
REQ-029 Reset release, then trig_i = 2'b01 for 1 cycle at timestamp 0x0005, m_tready = 1 -> one word with beams = 01 and timestamp = 0x0005, m_tvalid high 2 cycles after stimulus.
REQ-030 HOLDOFF = 4, trig_i = 2'b11 held high for 10 cycles starting at timestamp T -> words at T and T+5 only; the second word carries beams = 11.
REQ-031 mask_we_i with mask_i = 2'b10, next cycle trig_i = 2'b10 -> no event. trig_i = 2'b11 -> word with beams = 01.
REQ-032 m_tready = 0 and 6 separated events with FIFO_DEPTH = 4 -> 4 words retained in order, overflow_o = 2; then m_tready = 1 drains 4 words with the original timestamps.
REQ-033 300 dropped events -> overflow_o = 255. Then aresetn pulsed low mid-stream -> m_tvalid = 0 and overflow_o = 0 immediately, without waiting for a clock edge.
REQ-034 Timestamp counter preloaded near wrap, event at 0xFFFF and next event at 0x0004 -> words carry 0xFFFF then 0x0004.

Source files
------------

// File: rtl/pueo_beam_trig_out.sv
// Beam trigger event packer: masks per-beam trigger flags, applies a fixed holdoff
// after each accepted event and queues {timestamp, beams} words in a FWFT FIFO.
module pueo_beam_trig_out #(
    parameter int NUM_BEAMS  = 2,
    parameter int HOLDOFF    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [NUM_BEAMS-1:0]   trig_i,
    input  logic [NUM_BEAMS-1:0]   mask_i,
    input  logic                   mask_we_i,
    output logic [NUM_BEAMS+15:0]  m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [7:0]             overflow_o
);

    localparam int              DW        = NUM_BEAMS + 16;
    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]      HOLD_INIT = 8'(HOLDOFF - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [7:0]             r_hold_cnt;
    logic [7:0]             w_hold_next;
    logic                   w_event;

    logic [15:0]            r_ts;
    logic [NUM_BEAMS-1:0]   r_mask;
    logic [NUM_BEAMS-1:0]   w_eff;

    logic                   r_cap_valid;
    logic [DW-1:0]          r_cap_data;

    logic [DW-1:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;
    logic [7:0]             r_overflow;

    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BEAMS; gi++) begin : g_eff
            assign w_eff[gi] = trig_i[gi] & ~r_mask[gi];
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ts   <= 16'd0;
            r_mask <= '0;
        end else begin
            r_ts <= r_ts + 16'd1;
            if (mask_we_i) begin
                r_mask <= mask_i;
            end
        end
    end

    // Event FSM: trig_i is only looked at in IDLE, so HOLD ignores it entirely.
    always_comb begin
        w_state_next = r_state;
        w_hold_next  = r_hold_cnt;
        w_event      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_eff) begin
                    w_event      = 1'b1;
                    w_state_next = S_HOLD;
                    w_hold_next  = HOLD_INIT;
                end
            end
            S_HOLD: begin
                if (r_hold_cnt == 8'd0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_hold_next = r_hold_cnt - 8'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_hold_cnt  <= 8'd0;
            r_cap_valid <= 1'b0;
            r_cap_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_hold_cnt  <= w_hold_next;
            r_cap_valid <= w_event;
            if (w_event) begin
                r_cap_data <= {r_ts, w_eff};
            end
        end
    end

    // A push into a full FIFO is still accepted when the head is leaving in the same cycle.
    assign w_full = (r_count == DEPTH_C);
    assign w_pop  = m_tvalid & m_tready;
    assign w_push = r_cap_valid & (~w_full | w_pop);
    assign w_drop = r_cap_valid & w_full & ~w_pop;

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_cap_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 8'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_overflow != 8'hFF)) begin
                r_overflow <= r_overflow + 8'd1;
            end
        end
    end

    // Output word is gated so it reads zero whenever nothing is queued, including in reset.
    assign m_tvalid   = (r_count != '0);
    assign m_tdata    = m_tvalid ? r_mem[r_rd_ptr] : '0;
    assign overflow_o = r_overflow;

endmodule

// File: tb/tb_pueo_beam_trig_out.sv
// Self-checking bench for pueo_beam_trig_out: directed scenarios plus random traffic
// compared each cycle against a queue-based event model.
module tb_pueo_beam_trig_out;

    localparam int NB = 2;
    localparam int HO = 4;
    localparam int FD = 4;
    localparam int DW = NB + 16;

    logic            aclk;
    logic            aresetn;
    logic [NB-1:0]   trig_i;
    logic [NB-1:0]   mask_i;
    logic            mask_we_i;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic [7:0]      overflow_o;

    int checks = 0;
    int errors = 0;

    // Reference model: stored words, words observed leaving the DUT, and event bookkeeping.
    logic [DW-1:0]   mq[$];
    logic [DW-1:0]   got[$];
    logic [NB-1:0]   mdl_mask;
    int              cyc;
    int              next_ok;
    bit              pend_v;
    logic [DW-1:0]   pend_w;
    int              ovf;

    logic [15:0]     t0;
    logic [15:0]     exp_ts[6];
    logic [DW-1:0]   w_exp;

    pueo_beam_trig_out #(
        .NUM_BEAMS  (NB),
        .HOLDOFF    (HO),
        .FIFO_DEPTH (FD)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .trig_i     (trig_i),
        .mask_i     (mask_i),
        .mask_we_i  (mask_we_i),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .overflow_o (overflow_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mdl_mask = '0;
        cyc      = 0;
        next_ok  = 0;
        pend_v   = 1'b0;
        pend_w   = '0;
        ovf      = 0;
    endtask

    // One clock cycle: update the model from the inputs of this cycle, clock, then compare.
    task automatic step();
        logic [NB-1:0] eff;
        logic [15:0]   ts;
        bit            ev;
        bit            pop;
        if (aresetn) begin
            if (m_tvalid && m_tready) got.push_back(m_tdata);
            ts  = 16'(cyc);
            eff = trig_i & ~mdl_mask;
            ev  = (eff != '0) && (cyc >= next_ok);
            if (ev) next_ok = cyc + HO + 1;
            pop = (mq.size() != 0) && m_tready;
            if (pop) void'(mq.pop_front());
            if (pend_v) begin
                if (mq.size() < FD) mq.push_back(pend_w);
                else if (ovf < 255) ovf++;
            end
            pend_v = ev;
            pend_w = {ts, eff};
            if (mask_we_i) mdl_mask = mask_i;
            cyc++;
        end
        @(posedge aclk);
        #1;
        chk("tvalid", 32'(m_tvalid), 32'(mq.size() != 0));
        chk("tdata", 32'(m_tdata), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        chk("overflow", 32'(overflow_o), 32'(ovf));
    endtask

    // Assert reset between edges, check outputs clear without a clock, release after one edge.
    task automatic do_reset();
        aresetn = 1'b0;
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_overflow", 32'(overflow_o), 32'd0);
        model_reset();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    initial begin
        aresetn   = 1'b0;
        trig_i    = '0;
        mask_i    = '0;
        mask_we_i = 1'b0;
        m_tready  = 1'b1;
        model_reset();
        #1;
        do_reset();

        // Single event at timestamp 5, visible two cycles later.
        got.delete();
        while (cyc != 5) step();
        trig_i = 2'b01;
        step();
        trig_i = '0;
        chk("t029_valid_plus1", 32'(m_tvalid), 32'd0);
        step();
        chk("t029_valid_plus2", 32'(m_tvalid), 32'd1);
        w_exp = {16'h0005, 2'b01};
        chk("t029_word", 32'(m_tdata), 32'(w_exp));
        repeat (4) step();
        chk("t029_count", 32'(got.size()), 32'd1);

        // Trigger held for 10 cycles: holdoff allows events at T and T+5 only.
        got.delete();
        t0 = 16'(cyc);
        trig_i = 2'b11;
        repeat (10) step();
        trig_i = '0;
        repeat (6) step();
        chk("t030_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            w_exp = {t0, 2'b11};
            chk("t030_word0", 32'(got[0]), 32'(w_exp));
            w_exp = {t0 + 16'd5, 2'b11};
            chk("t030_word1", 32'(got[1]), 32'(w_exp));
        end

        // Mask beam 1: its trigger alone is ignored, both beams yield beams=01.
        got.delete();
        mask_i = 2'b10;
        mask_we_i = 1'b1;
        step();
        mask_we_i = 1'b0;
        trig_i = 2'b10;
        step();
        trig_i = '0;
        repeat (4) step();
        chk("t031_masked_none", 32'(got.size()), 32'd0);
        trig_i = 2'b11;
        step();
        trig_i = '0;
        repeat (4) step();
        chk("t031_count", 32'(got.size()), 32'd1);
        if (got.size() == 1) begin
            w_exp = got[0];
            chk("t031_beams", 32'(w_exp[NB-1:0]), 32'd1);
        end
        mask_i = '0;
        mask_we_i = 1'b1;
        step();
        mask_we_i = 1'b0;

        // Back-pressure: six events into a four-deep FIFO, two dropped, then drain in order.
        got.delete();
        m_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_ts[i] = 16'(cyc);
            trig_i = 2'b01;
            step();
            trig_i = '0;
            repeat (6) step();
        end
        chk("t032_overflow", 32'(overflow_o), 32'd2);
        m_tready = 1'b1;
        repeat (8) step();
        chk("t032_drained", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                w_exp = {exp_ts[i], 2'b01};
                chk("t032_order", 32'(got[i]), 32'(w_exp));
            end
        end

        // Random traffic against the model.
        repeat (400) begin
            trig_i = NB'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                mask_we_i = 1'b1;
                mask_i    = NB'($urandom);
            end else begin
                mask_we_i = 1'b0;
            end
            m_tready = ($urandom_range(0, 3) != 0);
            step();
        end
        trig_i = '0;
        mask_i = '0;
        mask_we_i = 1'b1;
        m_tready = 1'b1;
        step();
        mask_we_i = 1'b0;
        repeat (10) step();

        // Timestamp wrap: events at 0xFFFF and 0x0004.
        got.delete();
        while (16'(cyc) != 16'hFFFF) step();
        trig_i = 2'b01;
        step();
        trig_i = '0;
        while (16'(cyc) != 16'h0004) step();
        trig_i = 2'b10;
        step();
        trig_i = '0;
        repeat (5) step();
        chk("t034_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            w_exp = {16'hFFFF, 2'b01};
            chk("t034_word0", 32'(got[0]), 32'(w_exp));
            w_exp = {16'h0004, 2'b10};
            chk("t034_word1", 32'(got[1]), 32'(w_exp));
        end

        // Overflow saturation, then reset mid-stream with an event in flight.
        m_tready = 1'b0;
        repeat (304) begin
            trig_i = 2'b01;
            step();
            trig_i = '0;
            repeat (HO) step();
        end
        chk("t033_saturated", 32'(overflow_o), 32'd255);
        chk("t033_full_valid", 32'(m_tvalid), 32'd1);
        trig_i = 2'b01;
        step();
        trig_i = '0;
        do_reset();

        // First edge after reset release already detects an event at timestamp 0.
        got.delete();
        m_tready = 1'b1;
        trig_i = 2'b01;
        step();
        trig_i = '0;
        repeat (4) step();
        chk("t028_count", 32'(got.size()), 32'd1);
        if (got.size() == 1) begin
            w_exp = {16'h0000, 2'b01};
            chk("t028_word", 32'(got[0]), 32'(w_exp));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
